// File: rtl/weight_stream_loader.sv
// weight_stream_loader
// Write stage of the weight memory. It takes the weight AXI-stream and scatters
// the beats across NUMBER_OF_WEIGHT_LINE_BUFFERS banked line buffers. The order
// is bank first, then line, then buffer. It also checks the frame length
// against tlast.
//
// Ports
//   clk, reset            clock and synchronous active-high reset
//   i_start               pulse that starts a load; ignored unless idle
//   i_base_addr           first line address used in every buffer
//   i_line_count          lines per buffer for this load (0 is treated as 1)
//   s_axis_*              weight stream: one beat is one bank word
//   o_write_port_*        line-buffer write ports, registered, 1-cycle latency
//   o_busy                load or drain in progress
//   o_done                one-cycle pulse at the end of a load
//   o_error               sticky frame-length error, cleared by the next start
//
// Build option
//   WEIGHT_STREAM_LOADER_BEAT_COUNT_EN adds o_beat_count[31:0]. It counts the
//   beats accepted since the last start, drained beats included, and it
//   saturates at its maximum value.
//
// States
//   state | meaning
//   IDLE  | waiting for i_start, tready low
//   LOAD  | accepting beats and writing them to the line buffers
//   DRAIN | frame was too long, so beats are discarded until tlast

module weight_stream_loader #(
  parameter int WEIGHT_BANK_BIT_WIDTH         = 64,
  parameter int WEIGHT_BUFFER_BANK_COUNT      = 8,
  parameter int WEIGHT_LINE_BUFFER_DEPTH      = 512,
  parameter int NUMBER_OF_WEIGHT_LINE_BUFFERS = 3,
  localparam int ADDR_W = $clog2(WEIGHT_LINE_BUFFER_DEPTH),
  localparam int DW     = WEIGHT_BANK_BIT_WIDTH,
  localparam int BC     = WEIGHT_BUFFER_BANK_COUNT,
  localparam int NLB    = NUMBER_OF_WEIGHT_LINE_BUFFERS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_start,
  input  logic [ADDR_W-1:0]     i_base_addr,
  input  logic [ADDR_W:0]       i_line_count,
  input  logic [DW-1:0]         s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic [NLB-1:0]        o_write_port_enable,
  output logic [NLB*BC-1:0]     o_write_port_wen,
  output logic [NLB*ADDR_W-1:0] o_write_port_addr,
  output logic [DW*BC-1:0]      o_write_port_data_in,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error
`ifdef WEIGHT_STREAM_LOADER_BEAT_COUNT_EN
  ,
  output logic [31:0]           o_beat_count
`endif
);

  localparam int BANK_W = (BC > 1) ? $clog2(BC) : 1;
  localparam int BUF_W  = (NLB > 1) ? $clog2(NLB) : 1;
  localparam logic [BANK_W-1:0] BANK_LAST = BANK_W'(BC - 1);
  localparam logic [BUF_W-1:0]  BUF_LAST  = BUF_W'(NLB - 1);
  localparam logic [BANK_W-1:0] BANK_ONE  = BANK_W'(1);
  localparam logic [BUF_W-1:0]  BUF_ONE   = BUF_W'(1);
  localparam logic [ADDR_W-1:0] LINE_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     base_q, base_d;
  logic [ADDR_W:0]       count_q, count_d;
  logic [BANK_W-1:0]     bank_q, bank_d;
  logic [ADDR_W-1:0]     line_q, line_d;
  logic [BUF_W-1:0]      buf_q, buf_d;
  logic [NLB-1:0]        en_q, en_d;
  logic [NLB*BC-1:0]     wen_q, wen_d;
  logic [NLB*ADDR_W-1:0] addr_q, addr_d;
  logic [DW*BC-1:0]      data_q, data_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;

  logic                  ready;
  logic                  beat_acc;
  logic                  last_line;
  logic                  last_beat;
  logic [ADDR_W-1:0]     line_addr;

  assign ready    = (state_q != ST_IDLE);
  assign beat_acc = s_axis_tvalid && ready;

  assign last_line = ({1'b0, line_q} == (count_q - CNT_ONE));
  assign last_beat = (bank_q == BANK_LAST) && last_line && (buf_q == BUF_LAST);
  // The carry is dropped, so the address wraps modulo the buffer depth.
  assign line_addr = base_q + line_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      count_q <= '0;
      bank_q  <= '0;
      line_q  <= '0;
      buf_q   <= '0;
      en_q    <= '0;
      wen_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      count_q <= count_d;
      bank_q  <= bank_d;
      line_q  <= line_d;
      buf_q   <= buf_d;
      en_q    <= en_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    count_d = count_q;
    bank_d  = bank_q;
    line_d  = line_q;
    buf_d   = buf_q;
    en_d    = '0;
    wen_d   = '0;
    addr_d  = addr_q;
    data_d  = data_q;
    done_d  = 1'b0;
    error_d = error_q;

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_LOAD;
          base_d  = i_base_addr;
          count_d = (i_line_count == '0) ? CNT_ONE : i_line_count;
          bank_d  = '0;
          line_d  = '0;
          buf_d   = '0;
          error_d = 1'b0;
        end
      end

      ST_LOAD: begin
        if (beat_acc) begin
          for (int b = 0; b < NLB; b++) begin
            if (buf_q == BUF_W'(b)) begin
              en_d[b] = 1'b1;
            end
            for (int k = 0; k < BC; k++) begin
              if ((buf_q == BUF_W'(b)) && (bank_q == BANK_W'(k))) begin
                wen_d[b*BC + k] = 1'b1;
              end
            end
          end
          addr_d = {NLB{line_addr}};
          data_d = {BC{s_axis_tdata}};

          if (last_beat && s_axis_tlast) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else if (s_axis_tlast) begin
            // The frame ended early. The lines written so far are kept.
            state_d = ST_IDLE;
            done_d  = 1'b1;
            error_d = 1'b1;
          end else if (last_beat) begin
            // The frame is too long. Discard the rest of it up to tlast.
            state_d = ST_DRAIN;
            error_d = 1'b1;
          end else if (bank_q == BANK_LAST) begin
            bank_d = '0;
            if (last_line) begin
              line_d = '0;
              buf_d  = buf_q + BUF_ONE;
            end else begin
              line_d = line_q + LINE_ONE;
            end
          end else begin
            bank_d = bank_q + BANK_ONE;
          end
        end
      end

      ST_DRAIN: begin
        if (beat_acc && s_axis_tlast) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign s_axis_tready        = ready;
  assign o_busy               = ready;
  assign o_write_port_enable  = en_q;
  assign o_write_port_wen     = wen_q;
  assign o_write_port_addr    = addr_q;
  assign o_write_port_data_in = data_q;
  assign o_done               = done_q;
  assign o_error              = error_q;

`ifdef WEIGHT_STREAM_LOADER_BEAT_COUNT_EN
  logic [31:0] beat_cnt_q, beat_cnt_d;

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if ((state_q == ST_IDLE) && i_start) begin
      beat_cnt_d = '0;
    end else if (beat_acc && (beat_cnt_q != 32'hFFFF_FFFF)) begin
      beat_cnt_d = beat_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      beat_cnt_q <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign o_beat_count = beat_cnt_q;
`endif

endmodule

// File: tb/tb_weight_stream_loader.sv
// Testbench for weight_stream_loader. A scoreboard queue holds one expected
// write per accepted beat. Each entry is popped when the write port reports it.

module tb_weight_stream_loader;

  localparam int DW = 64;
  localparam int BC = 8;
  localparam int DEPTH = 512;
  localparam int NLB = 3;
  localparam int AW = 9;

  typedef struct {
    int                  stamp;
    logic [NLB-1:0]      en;
    logic [NLB*BC-1:0]   wen;
    logic [NLB*AW-1:0]   addr;
    logic [DW*BC-1:0]    data;
  } wr_t;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                i_start = 1'b0;
  logic [AW-1:0]       i_base_addr = '0;
  logic [AW:0]         i_line_count = '0;
  logic [DW-1:0]       s_axis_tdata = '0;
  logic                s_axis_tvalid = 1'b0;
  logic                s_axis_tlast = 1'b0;
  logic                s_axis_tready;
  logic [NLB-1:0]      o_write_port_enable;
  logic [NLB*BC-1:0]   o_write_port_wen;
  logic [NLB*AW-1:0]   o_write_port_addr;
  logic [DW*BC-1:0]    o_write_port_data_in;
  logic                o_busy;
  logic                o_done;
  logic                o_error;
`ifdef WEIGHT_STREAM_LOADER_BEAT_COUNT_EN
  logic [31:0]         o_beat_count;
`endif

  int n_vec = 0;
  int n_mis = 0;
  int cyc = 0;
  int done_cnt = 0;
  wr_t sb[$];

  weight_stream_loader dut (
    .clk                  (clk),
    .reset                (reset),
    .i_start              (i_start),
    .i_base_addr          (i_base_addr),
    .i_line_count         (i_line_count),
    .s_axis_tdata         (s_axis_tdata),
    .s_axis_tvalid        (s_axis_tvalid),
    .s_axis_tlast         (s_axis_tlast),
    .s_axis_tready        (s_axis_tready),
    .o_write_port_enable  (o_write_port_enable),
    .o_write_port_wen     (o_write_port_wen),
    .o_write_port_addr    (o_write_port_addr),
    .o_write_port_data_in (o_write_port_data_in),
    .o_busy               (o_busy),
    .o_done               (o_done),
    .o_error              (o_error)
`ifdef WEIGHT_STREAM_LOADER_BEAT_COUNT_EN
    ,
    .o_beat_count         (o_beat_count)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write-port monitor: a write must appear exactly in the cycle that the
  // scoreboard head names. Any other write is spurious.
  always @(negedge clk) begin
    if (o_done === 1'b1) done_cnt++;
    if (sb.size() > 0 && sb[0].stamp == cyc) begin
      wr_t e;
      e = sb.pop_front();
      chk("wr_en",   512'(o_write_port_enable),  512'(e.en));
      chk("wr_wen",  512'(o_write_port_wen),     512'(e.wen));
      chk("wr_addr", 512'(o_write_port_addr),    512'(e.addr));
      chk("wr_data", o_write_port_data_in,       e.data);
    end else if (o_write_port_wen != '0 || o_write_port_enable != '0) begin
      chk("spurious_wr", 512'({o_write_port_enable, o_write_port_wen}), 512'(0));
    end
  end

  task automatic push_beat(input int k, input int eff, input logic [AW-1:0] base,
                           input logic [DW-1:0] d);
    wr_t e;
    int bank, line, bf;
    logic [AW-1:0] a;
    bank = k % BC;
    line = (k / BC) % eff;
    bf   = k / (BC * eff);
    a    = AW'((int'(base) + line) % DEPTH);
    e.stamp = cyc + 1;
    e.en    = NLB'(1) << bf;
    e.wen   = (NLB*BC)'(1) << (bf * BC + bank);
    e.addr  = {NLB{a}};
    e.data  = {BC{d}};
    sb.push_back(e);
  endtask

  // Runs one load. The beat with index tlast_at carries tlast. If start_at
  // matches a beat index, a stray i_start is raised on that beat. If reset_at
  // matches a beat index, reset is raised on that beat and the task stops.
  task automatic run_frame(input logic [AW-1:0] base, input logic [AW:0] cnt,
                           input int nbeats, input int tlast_at, input bit toggle,
                           input int start_at, input int reset_at, input bit inc_data);
    int eff, total, k, it, d0;
    logic [DW-1:0] d;
    eff   = (cnt == 0) ? 1 : int'(cnt);
    total = NLB * eff * BC;
    d0    = done_cnt;
    k = 0;
    it = 0;
    @(negedge clk);
    i_start = 1'b1;
    i_base_addr = base;
    i_line_count = cnt;
    @(negedge clk);
    i_start = 1'b0;
    i_base_addr = base + AW'(37);
    i_line_count = cnt + 3;
    chk("busy_after_start", 512'(o_busy), 512'(1));
    chk("err_cleared", 512'(o_error), 512'(0));
    while (k < nbeats) begin
      s_axis_tvalid = toggle ? (it % 2 == 0) : 1'b1;
      d = inc_data ? DW'(k) : {$urandom, $urandom};
      s_axis_tdata = d;
      s_axis_tlast = (k == tlast_at);
      i_start = (k == start_at);
      if (k == reset_at) reset = 1'b1;
      #1;
      if (s_axis_tvalid) begin
        if (k == 0) chk("tready_load", 512'(s_axis_tready), 512'(1));
        if (k != reset_at && k < total) push_beat(k, eff, base, d);
        if (k == reset_at) begin
          @(negedge clk);
          reset = 1'b0;
          s_axis_tvalid = 1'b0;
          s_axis_tlast = 1'b0;
          i_start = 1'b0;
          chk("rst_wr_out", 512'({o_write_port_enable, o_write_port_wen}), 512'(0));
          chk("rst_addr", 512'(o_write_port_addr), 512'(0));
          chk("rst_data", o_write_port_data_in, 512'(0));
          chk("rst_ctrl", 512'({s_axis_tready, o_busy, o_done, o_error}), 512'(0));
          return;
        end
        k++;
      end
      it++;
      @(negedge clk);
      i_start = 1'b0;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    chk("done_pulse", 512'(o_done), 512'(1));
    chk("error_flag", 512'(o_error), 512'(tlast_at != total - 1));
    chk("idle_after", 512'({o_busy, s_axis_tready}), 512'(0));
    @(negedge clk);
    #1;
    chk("done_low", 512'(o_done), 512'(0));
    chk("done_once", 512'(done_cnt - d0), 512'(1));
    chk("sb_empty", 512'(sb.size()), 512'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_ctrl", 512'({s_axis_tready, o_busy, o_done, o_error}), 512'(0));
    chk("reset_wr", 512'({o_write_port_enable, o_write_port_wen, o_write_port_addr}), 512'(0));
    chk("reset_data", o_write_port_data_in, 512'(0));
    reset = 1'b0;

    // Legal frame: base 0, 2 lines, data equal to the beat index.
    run_frame(9'd0, 10'd2, 48, 47, 1'b0, -1, -1, 1'b1);
`ifdef WEIGHT_STREAM_LOADER_BEAT_COUNT_EN
    chk("beat_count", 512'(o_beat_count), 512'(48));
`endif
    // Address wrap past the top of the buffer, with a stray i_start mid-load.
    run_frame(9'd510, 10'd4, 96, 95, 1'b0, 30, -1, 1'b0);
    // Valid toggling on every cycle.
    run_frame(9'd0, 10'd2, 48, 47, 1'b1, -1, -1, 1'b1);
    // tlast arrives early on beat 10.
    run_frame(9'd5, 10'd2, 11, 10, 1'b0, -1, -1, 1'b0);
    // No tlast on the last expected beat. tlast arrives on beat 52.
    run_frame(9'd0, 10'd2, 53, 52, 1'b1, -1, -1, 1'b0);
    // A line count of 0 behaves as 1.
    run_frame(9'd300, 10'd0, 24, 23, 1'b0, -1, -1, 1'b0);
    // Reset during beat 20, then a fresh load.
    run_frame(9'd0, 10'd2, 48, 47, 1'b0, -1, 20, 1'b1);
    chk("sb_after_reset", 512'(sb.size()), 512'(0));
    run_frame(9'd100, 10'd1, 24, 23, 1'b0, -1, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
